fifo_pop_stream: RTL and testbench

FIFO_POP_STREAM -- requirements
Module: fifo_pop_stream

---
 rtl/fifo_pop_stream.sv | 84 ++++++++
 tb/tb_fifo_pop_stream.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_stream.sv
// Pops an upstream show-ahead FIFO into a valid/ready stream through a 2-entry skid buffer.
// The buffer decouples fifo_pop_o from ready_i and counts completed output beats.
//
// state | meaning
// EMPTY | no buffered entries, valid_o low
// ONE   | one entry buffered, still popping upstream
// TWO   | buffer full, upstream popping paused
module fifo_pop_stream #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [15:0]           beat_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] slot [2];
  logic                  head_ptr;
  logic                  tail_ptr;
  logic                  push;
  logic                  handshake;

  always_comb begin
    push       = !fifo_empty_i && !flush_i && !rst_i && (state != TWO);
    fifo_pop_o = push;
    valid_o    = (state != EMPTY) && !flush_i && !rst_i;
    handshake  = valid_o && ready_i;
    // Slots may hold stale pre-reset contents until the first reset edge.
    data_o     = rst_i ? '0 : slot[head_ptr];
    state_nxt  = state;
    if (flush_i) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (push) state_nxt = ONE;
        ONE: begin
          if (push && !handshake)      state_nxt = TWO;
          else if (!push && handshake) state_nxt = EMPTY;
        end
        TWO:     if (handshake) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= EMPTY;
      slot[0]    <= '0;
      slot[1]    <= '0;
      head_ptr   <= 1'b0;
      tail_ptr   <= 1'b0;
      beat_cnt_o <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (push) begin
        slot[tail_ptr] <= fifo_data_i;
        tail_ptr       <= ~tail_ptr;
      end
      if (flush_i) begin
        head_ptr <= 1'b0;
        tail_ptr <= 1'b0;
      end else if (handshake) begin
        head_ptr <= ~head_ptr;
      end
      if (handshake) beat_cnt_o <= beat_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Directed and scoreboarded checks of fifo_pop_stream: streaming, backpressure, flush,
// counter wrap, mid-stream reset and a randomly gapped upstream.
module tb_fifo_pop_stream;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        fifo_empty_i;
  logic [31:0] fifo_data_i;
  logic        fifo_pop_o;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic [15:0] beat_cnt_o;

  int checks   = 0;
  int failures = 0;

  fifo_pop_stream #(.DATA_WIDTH(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_pop_o   (fifo_pop_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (data_o),
    .beat_cnt_o   (beat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after an edge and let them settle well before the next one.
  task automatic drive(input logic rst, input logic flush, input logic empty,
                       input logic [31:0] data, input logic ready);
    rst_i        = rst;
    flush_i      = flush;
    fifo_empty_i = empty;
    fifo_data_i  = data;
    ready_i      = ready;
    #2;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [31:0] sb[$];
  logic [31:0] nxt_val;
  logic [15:0] exp_cnt;
  int          occ;
  logic        e, r, exp_pop, exp_valid;

  initial begin
    drive(1, 0, 0, 32'hDEAD, 1);
    tick();
    tick();
    // reset holds outputs low even with data upstream
    drive(1, 0, 0, 32'hDEAD, 1);
    check("rst_pop", fifo_pop_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_cnt", beat_cnt_o, 0);
    drive(1, 1, 0, 32'hDEAD, 1);
    check("rst_flush_pop", fifo_pop_o, 0);
    tick();

    // streaming A,B,C
    drive(0, 0, 0, 32'hA, 1);
    check("s0_pop", fifo_pop_o, 1);
    check("s0_valid", valid_o, 0);
    tick();
    drive(0, 0, 0, 32'hB, 1);
    check("s1_pop", fifo_pop_o, 1);
    check("s1_valid", valid_o, 1);
    check("s1_data", data_o, 32'hA);
    tick();
    drive(0, 0, 0, 32'hC, 1);
    check("s2_pop", fifo_pop_o, 1);
    check("s2_data", data_o, 32'hB);
    tick();
    drive(0, 0, 1, 32'h0, 1);
    check("s3_pop", fifo_pop_o, 0);
    check("s3_valid", valid_o, 1);
    check("s3_data", data_o, 32'hC);
    tick();
    drive(0, 0, 1, 32'h0, 1);
    check("s4_valid", valid_o, 0);
    check("s4_cnt", beat_cnt_o, 3);

    // backpressure
    drive(0, 0, 0, 32'h11, 0);
    check("b0_pop", fifo_pop_o, 1);
    tick();
    drive(0, 0, 0, 32'h22, 0);
    check("b1_pop", fifo_pop_o, 1);
    check("b1_data", data_o, 32'h11);
    tick();
    drive(0, 0, 0, 32'h33, 0);
    check("b2_pop_full", fifo_pop_o, 0);
    check("b2_valid", valid_o, 1);
    check("b2_data", data_o, 32'h11);
    tick();
    drive(0, 0, 0, 32'h33, 0);
    check("b3_data_stable", data_o, 32'h11);
    drive(0, 0, 0, 32'h33, 1);
    check("b4_pop_full_hs", fifo_pop_o, 0);
    check("b4_data", data_o, 32'h11);
    tick();
    drive(0, 0, 0, 32'h33, 1);
    check("b5_pop_resume", fifo_pop_o, 1);
    check("b5_data", data_o, 32'h22);
    tick();
    drive(0, 0, 1, 32'h0, 0);
    check("b6_valid", valid_o, 1);
    check("b6_data", data_o, 32'h33);
    check("b6_cnt", beat_cnt_o, 5);

    // fill to TWO, then flush
    drive(0, 0, 0, 32'h44, 0);
    check("f0_pop", fifo_pop_o, 1);
    tick();
    drive(0, 1, 0, 32'h55, 1);
    check("f1_valid", valid_o, 0);
    check("f1_pop", fifo_pop_o, 0);
    tick();
    drive(0, 0, 1, 32'h0, 1);
    check("f2_valid", valid_o, 0);
    check("f2_cnt", beat_cnt_o, 5);

    // mid-stream reset from ONE
    drive(0, 0, 0, 32'h55, 0);
    check("r0_pop", fifo_pop_o, 1);
    tick();
    drive(0, 0, 1, 32'h0, 0);
    check("r1_valid", valid_o, 1);
    check("r1_data", data_o, 32'h55);
    drive(1, 0, 0, 32'h66, 1);
    check("r2_valid", valid_o, 0);
    check("r2_pop", fifo_pop_o, 0);
    check("r2_data", data_o, 0);
    tick();
    drive(0, 0, 0, 32'h77, 1);
    check("r3_valid", valid_o, 0);
    check("r3_pop", fifo_pop_o, 1);
    check("r3_cnt", beat_cnt_o, 0);
    tick();
    drive(0, 0, 1, 32'h0, 1);
    check("r4_valid", valid_o, 1);
    check("r4_data", data_o, 32'h77);
    tick();
    drive(0, 0, 1, 32'h0, 1);
    check("r5_valid", valid_o, 0);
    check("r5_cnt", beat_cnt_o, 1);

    // stream 65533 beats to bring the counter to 0xFFFE
    for (int j = 0; j < 65533; j++) begin
      drive(0, 0, 0, j, 1);
      check("w_valid", valid_o, (j > 0) ? 1 : 0);
      if (j > 0) check("w_data", data_o, j - 1);
      tick();
    end
    drive(0, 0, 1, 32'h0, 1);
    check("w_last", data_o, 65532);
    tick();
    drive(0, 0, 1, 32'h0, 1);
    check("w_idle", valid_o, 0);
    check("w_cnt_fffe", beat_cnt_o, 16'hFFFE);
    drive(0, 0, 0, 32'hA0, 1);
    tick();
    drive(0, 0, 0, 32'hA1, 1);
    check("w_cnt_fffe2", beat_cnt_o, 16'hFFFE);
    tick();
    drive(0, 0, 0, 32'hA2, 1);
    check("w_cnt_ffff", beat_cnt_o, 16'hFFFF);
    tick();
    drive(0, 0, 1, 32'h0, 1);
    check("w_cnt_0000", beat_cnt_o, 16'h0000);
    check("w_data_a2", data_o, 32'hA2);
    tick();
    drive(0, 0, 1, 32'h0, 1);
    check("w_cnt_0001", beat_cnt_o, 16'h0001);

    // random upstream gaps and backpressure against a scoreboard
    occ     = 0;
    nxt_val = 32'h1000;
    exp_cnt = 16'h0001;
    for (int k = 0; k < 400; k++) begin
      e = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      drive(0, 0, e, nxt_val, r);
      exp_pop   = !e && (occ < 2);
      exp_valid = (occ > 0);
      check("x_pop", fifo_pop_o, exp_pop);
      check("x_valid", valid_o, exp_valid);
      if (exp_valid) check("x_data", data_o, sb[0]);
      tick();
      if (exp_valid && r) begin
        void'(sb.pop_front());
        occ--;
        exp_cnt++;
      end
      if (exp_pop) begin
        sb.push_back(nxt_val);
        nxt_val++;
        occ++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 32'h0, 1);
      check("d_valid", valid_o, (occ > 0) ? 1 : 0);
      if (occ > 0) begin
        check("d_data", data_o, sb[0]);
        void'(sb.pop_front());
        occ--;
        exp_cnt++;
      end
      tick();
    end
    drive(0, 0, 1, 32'h0, 1);
    check("x_cnt", beat_cnt_o, exp_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
